// File: rtl/ear_pkg.sv
// ear_pkg: shared state encoding and constants for the EAR tape detector.
package ear_pkg;
    localparam int SAMPLE_W = 16;
    localparam int DC_SHIFT = 8;
    typedef enum logic [1:0] {SQUELCH, LOW, HIGH} ear_state_e;
endpackage

// File: rtl/ear_dc_tracker.sv
// ear_dc_tracker: first-order DC offset follower, offset moves 1/256 of the error per sample.
module ear_dc_tracker
    import ear_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic signed [SAMPLE_W-1:0] mix,
    output logic signed [SAMPLE_W-1:0] offset
);
    logic signed [SAMPLE_W:0] diff, sum;
    always_comb begin
        diff = $signed({mix[SAMPLE_W-1], mix}) - $signed({offset[SAMPLE_W-1], offset});
        sum  = $signed({offset[SAMPLE_W-1], offset}) + (diff >>> DC_SHIFT);
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) offset <= '0;
        else if (en) offset <= sum[SAMPLE_W-1:0];
endmodule

// File: rtl/ear_detector.sv
// ear_detector: line-in to tape EAR bit slicer with hysteresis, edge counter and activity squelch.
// Optional DC tracking of the slicing level is enabled by defining EAR_DC_TRACK_EN.
module ear_detector
    import ear_pkg::*;
#(
    parameter logic signed [15:0] HYST        = 16'sd1024,
    parameter logic [23:0]        ACT_TIMEOUT = 24'd3500000
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] pcm_inl,
    input  logic signed [SAMPLE_W-1:0] pcm_inr,
    input  logic                       pcm_valid,
    input  logic                       edge_clr,
    output logic                       ear,
    output logic                       ear_edge,
    output logic                       activity,
    output logic [15:0]                edge_cnt
);
    ear_state_e state, state_nx;
    logic signed [SAMPLE_W-1:0] mix, offset;
    logic signed [SAMPLE_W:0] sum, x, hyst;
    logic [23:0] timer, timer_nx;
    logic mix_vld, hi, lo, ear_nx, edge_nx;

    assign sum = $signed({pcm_inl[SAMPLE_W-1], pcm_inl}) + $signed({pcm_inr[SAMPLE_W-1], pcm_inr});

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            mix     <= '0;
            mix_vld <= 1'b0;
        end else begin
            mix_vld <= pcm_valid;
            if (pcm_valid) mix <= sum[SAMPLE_W:1];
        end

`ifdef EAR_DC_TRACK_EN
    ear_dc_tracker u_dc (.clk(clk), .reset(reset), .en(mix_vld), .mix(mix), .offset(offset));
`else
    assign offset = '0;
`endif

    assign x        = $signed({mix[SAMPLE_W-1], mix}) - $signed({offset[SAMPLE_W-1], offset});
    assign hyst     = $signed({HYST[15], HYST});
    assign hi       = mix_vld && (x > hyst);
    assign lo       = mix_vld && (x < -hyst);
    assign activity = timer != '0;

    // Leaving SQUELCH only re-establishes the level; edges are counted between LOW and HIGH.
    always_comb begin
        state_nx = hi ? HIGH : lo ? LOW : (timer == 24'd1) ? SQUELCH : state;
        ear_nx   = (state_nx == SQUELCH) ? ear : (state_nx == HIGH);
        edge_nx  = (state != SQUELCH) && (ear_nx != ear);
        timer_nx = edge_nx ? ACT_TIMEOUT : (timer != '0) ? timer - 24'd1 : timer;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state    <= SQUELCH;
            ear      <= 1'b0;
            ear_edge <= 1'b0;
            timer    <= '0;
            edge_cnt <= '0;
        end else begin
            state    <= state_nx;
            ear      <= ear_nx;
            ear_edge <= edge_nx;
            timer    <= timer_nx;
            edge_cnt <= edge_clr ? '0 : (edge_nx && edge_cnt != 16'hFFFF) ? edge_cnt + 16'd1 : edge_cnt;
        end
endmodule
